// File: rtl/ras_pkg.sv
// Shared parameters and types for the return-address stack.
package ras_pkg;

    localparam int RAS_DEPTH   = 8;
    localparam int RAS_ENTRY_W = 64;
    localparam int RAS_PTR_W   = $clog2(RAS_DEPTH);

    typedef logic [RAS_PTR_W-1:0] ras_ptr_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with tail restore for mispredict recovery.
// Define RAS_STACK_STATUS_EN to expose empty/full/count status outputs.
module ras_stack
    import ras_pkg::*;
#(
    parameter int STACK_DEPTH = RAS_DEPTH,
    parameter int ENTRY_SIZE  = RAS_ENTRY_W
) (
    input  logic                           clk_in,
    input  logic                           rst_N_in,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ENTRY_SIZE-1:0]          pushee,
    input  logic                           restoreTail,
    input  logic [$clog2(STACK_DEPTH)-1:0] newTail,
`ifdef RAS_STACK_STATUS_EN
    output logic                           empty_out,
    output logic                           full_out,
    output logic [$clog2(STACK_DEPTH):0]   count_out,
`endif
    output logic [ENTRY_SIZE-1:0]          stack_out
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

    logic [ENTRY_SIZE-1:0] mem [STACK_DEPTH];
    logic [PW-1:0]         tail;
    logic [PW-1:0]         tail_n;
    logic [PW-1:0]         top;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_n;
    logic                  wr_en;
    logic [PW-1:0]         wr_idx;
    logic                  empty;

    assign top   = tail - 1'b1;
    assign empty = (count == '0);

    always_comb begin
        tail_n  = tail;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = tail;
        if (restoreTail) begin
            tail_n = newTail;
        end else if (push && pop && !empty) begin
            // Call and return in one cycle: the top is replaced in place.
            wr_en  = 1'b1;
            wr_idx = top;
        end else if (push) begin
            wr_en   = 1'b1;
            wr_idx  = tail;
            tail_n  = tail + 1'b1;
            count_n = (count == FULL) ? FULL : count + 1'b1;
        end else if (pop && !empty) begin
            tail_n  = top;
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_N_in) begin
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tail  <= tail_n;
            count <= count_n;
            if (wr_en) begin
                mem[wr_idx] <= pushee;
            end
        end
    end

    assign stack_out = empty ? '0 : mem[top];

`ifdef RAS_STACK_STATUS_EN
    assign empty_out = empty;
    assign full_out  = (count == FULL);
    assign count_out = count;
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack.
// Status outputs are checked when RAS_STACK_STATUS_EN is defined.
module tb_ras_stack;
    import ras_pkg::*;

    logic             clk_in = 1'b0;
    logic             rst_N_in;
    logic             push;
    logic             pop;
    logic [63:0]      pushee;
    logic             restoreTail;
    ras_ptr_t         newTail;
    logic [63:0]      stack_out;
`ifdef RAS_STACK_STATUS_EN
    logic             empty_out;
    logic             full_out;
    logic [3:0]       count_out;
`endif

    int total = 0;
    int bad   = 0;

    ras_stack dut (
        .clk_in      (clk_in),
        .rst_N_in    (rst_N_in),
        .push        (push),
        .pop         (pop),
        .pushee      (pushee),
        .restoreTail (restoreTail),
        .newTail     (newTail),
`ifdef RAS_STACK_STATUS_EN
        .empty_out   (empty_out),
        .full_out    (full_out),
        .count_out   (count_out),
`endif
        .stack_out   (stack_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic ps, input logic pp, input logic [63:0] d,
                       input logic rs, input ras_ptr_t nt, input logic rst);
        push        = ps;
        pop         = pp;
        pushee      = d;
        restoreTail = rs;
        newTail     = nt;
        rst_N_in    = rst;
        @(posedge clk_in);
        #1;
        push        = 1'b0;
        pop         = 1'b0;
        pushee      = '0;
        restoreTail = 1'b0;
        newTail     = '0;
        rst_N_in    = 1'b0;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 64'h0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_push(input logic [63:0] d);
        cyc(1'b1, 1'b0, d, 1'b0, '0, 1'b0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 1'b1, 64'h0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        push = 0; pop = 0; pushee = '0;
        restoreTail = 0; newTail = '0; rst_N_in = 1'b1;

        // Reset state
        do_reset();
        check("reset_out", stack_out, 64'h0);
`ifdef RAS_STACK_STATUS_EN
        check("reset_empty", {63'b0, empty_out}, 64'h1);
        check("reset_full", {63'b0, full_out}, 64'h0);
        check("reset_count", {60'b0, count_out}, 64'h0);
`endif

        // Basic push/pop
        do_push(64'h100);
        check("push1", stack_out, 64'h100);
        do_push(64'h200);
        check("push2", stack_out, 64'h200);
        do_pop();
        check("pop1", stack_out, 64'h100);
        do_pop();
        check("pop2", stack_out, 64'h0);

        // Underflow ignored, no tail skew
        do_pop();
        check("pop_empty", stack_out, 64'h0);
        do_push(64'h40);
        check("push_after_uf", stack_out, 64'h40);

        // Overflow drops oldest
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            do_push(64'(i));
        end
        check("ovf_top", stack_out, 64'h9);
`ifdef RAS_STACK_STATUS_EN
        check("ovf_full", {63'b0, full_out}, 64'h1);
        check("ovf_count", {60'b0, count_out}, 64'h8);
`endif
        for (int i = 8; i >= 2; i--) begin
            do_pop();
            check($sformatf("ovf_pop%0d", i), stack_out, 64'(i));
        end
        do_pop();
        check("ovf_drained", stack_out, 64'h0);
`ifdef RAS_STACK_STATUS_EN
        check("ovf_empty", {63'b0, empty_out}, 64'h1);
`endif

        // Simultaneous push and pop replaces top
        do_reset();
        do_push(64'hA);
        do_push(64'hB);
        cyc(1'b1, 1'b1, 64'hC, 1'b0, '0, 1'b0);
        check("pp_top", stack_out, 64'hC);
`ifdef RAS_STACK_STATUS_EN
        check("pp_count", {60'b0, count_out}, 64'h2);
`endif
        do_pop();
        check("pp_pop", stack_out, 64'hA);

        // Push+pop on empty acts as push
        do_reset();
        cyc(1'b1, 1'b1, 64'h77, 1'b0, '0, 1'b0);
        check("pp_empty", stack_out, 64'h77);

        // Restore tail beats push
        do_reset();
        do_push(64'h10);
        do_push(64'h20);
        do_push(64'h30);
        cyc(1'b1, 1'b0, 64'hDEAD, 1'b1, ras_ptr_t'(1), 1'b0);
        check("restore_top", stack_out, 64'h10);
`ifdef RAS_STACK_STATUS_EN
        check("restore_count", {60'b0, count_out}, 64'h3);
`endif
        do_push(64'h50);
        check("restore_push", stack_out, 64'h50);
        do_pop();
        check("restore_pop", stack_out, 64'h10);

        // Reset beats push
        do_push(64'h55);
        cyc(1'b1, 1'b0, 64'h66, 1'b0, '0, 1'b1);
        check("rst_push_out", stack_out, 64'h0);
`ifdef RAS_STACK_STATUS_EN
        check("rst_push_empty", {63'b0, empty_out}, 64'h1);
`endif
        do_push(64'h99);
        check("post_rst_push", stack_out, 64'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
